// File: rtl/alu_regfile_sequencer.sv
// Multi-cycle sequencer: accepts one instruction, reads operands, runs the ALU, writes back.
// Optional macro ALU_SEQ_R0_ZERO_EN makes register 0 read as zero and ignore writes.
module alu_regfile_sequencer #(
  parameter int unsigned OP_W = 4,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic            register_clk,
  input  logic            register_rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [OP_W-1:0] instr_op,
  input  logic [AW-1:0]   instr_rs1,
  input  logic [AW-1:0]   instr_rs2,
  input  logic [AW-1:0]   instr_rd,
  input  logic [4:0]      instr_shift,
  input  logic            instr_load,
  input  logic [DW-1:0]   instr_imm,
  output logic [AW-1:0]   read_reg1,
  output logic [AW-1:0]   read_reg2,
  input  logic [DW-1:0]   read_data1,
  input  logic [DW-1:0]   read_data2,
  output logic [DW-1:0]   alu_r1,
  output logic [DW-1:0]   alu_r2,
  output logic [4:0]      alu_shift,
  output logic [OP_W-1:0] alu_op,
  input  logic [DW-1:0]   alu_out,
  output logic            write_ctrl,
  output logic [DW-1:0]   wd,
  output logic [AW-1:0]   write_reg,
  output logic            write_enable,
  output logic            done_valid,
  output logic [DW-1:0]   done_result,
  output logic            done_err
);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [AW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [4:0]      shift_q, shift_d;
  logic            load_q, load_d;
  logic [DW-1:0]   imm_q, imm_d;
  logic [DW-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [DW-1:0]   result_q, result_d;
  logic            err_q, err_d;
  logic            rd_writable;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    shift_d  = shift_q;
    load_d   = load_q;
    imm_d    = imm_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          op_d    = instr_op;
          rs1_d   = instr_rs1;
          rs2_d   = instr_rs2;
          rd_d    = instr_rd;
          shift_d = instr_shift;
          load_d  = instr_load;
          imm_d   = instr_imm;
          err_d   = 1'b0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (load_q) begin
          state_d = StWrite;
        end else begin
`ifdef ALU_SEQ_R0_ZERO_EN
          opa_d = (rs1_q == '0) ? '0 : read_data1;
          opb_d = (rs2_q == '0) ? '0 : read_data2;
`else
          opa_d = read_data1;
          opb_d = read_data2;
`endif
          state_d = StExec;
        end
      end
      StExec: begin
        if (op_q < OP_W'(7)) begin
          result_d = alu_out;
        end else if (op_q < OP_W'(9)) begin
          // max/min of equal operands is either operand; take r1 directly
          result_d = (opa_q == opb_q) ? opa_q : alu_out;
        end else begin
          result_d = '0;
          err_d    = 1'b1;
        end
        state_d = StWrite;
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge register_clk) begin
    if (register_rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      shift_q  <= '0;
      load_q   <= 1'b0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      shift_q  <= shift_d;
      load_q   <= load_d;
      imm_q    <= imm_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

`ifdef ALU_SEQ_R0_ZERO_EN
  assign rd_writable = (rd_q != '0);
`else
  assign rd_writable = 1'b1;
`endif

  assign instr_ready  = (state_q == StIdle);
  assign read_reg1    = rs1_q;
  assign read_reg2    = rs2_q;
  assign alu_r1       = opa_q;
  assign alu_r2       = opb_q;
  assign alu_shift    = shift_q;
  assign alu_op       = op_q;
  assign write_ctrl   = ~load_q;
  assign wd           = imm_q;
  assign write_reg    = rd_q;
  assign done_valid   = (state_q == StWrite);
  assign write_enable = done_valid & ~err_q & rd_writable;
  assign done_result  = load_q ? imm_q : result_q;
  assign done_err     = done_valid & err_q;

endmodule

// File: tb/tb_alu_regfile_sequencer.sv
// Bench for alu_regfile_sequencer: behavioural register file and ALU around the DUT,
// directed instructions with a scoreboard checked by an independent completion monitor.
module tb_alu_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  instr_op = '0;
  logic [4:0]  instr_rs1 = '0, instr_rs2 = '0, instr_rd = '0;
  logic [4:0]  instr_shift = '0;
  logic        instr_load = 1'b0;
  logic [31:0] instr_imm = '0;
  logic [4:0]  read_reg1, read_reg2;
  logic [31:0] read_data1, read_data2;
  logic [31:0] alu_r1, alu_r2;
  logic [4:0]  alu_shift;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        write_ctrl;
  logic [31:0] wd;
  logic [4:0]  write_reg;
  logic        write_enable;
  logic        done_valid;
  logic [31:0] done_result;
  logic        done_err;

  always #5 clk = ~clk;

  alu_regfile_sequencer #(.OP_W(4), .AW(5), .DW(32)) dut (
    .register_clk (clk),
    .register_rst (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_rs1    (instr_rs1),
    .instr_rs2    (instr_rs2),
    .instr_rd     (instr_rd),
    .instr_shift  (instr_shift),
    .instr_load   (instr_load),
    .instr_imm    (instr_imm),
    .read_reg1    (read_reg1),
    .read_reg2    (read_reg2),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .alu_r1       (alu_r1),
    .alu_r2       (alu_r2),
    .alu_shift    (alu_shift),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .write_ctrl   (write_ctrl),
    .wd           (wd),
    .write_reg    (write_reg),
    .write_enable (write_enable),
    .done_valid   (done_valid),
    .done_result  (done_result),
    .done_err     (done_err)
  );

  // Environment: register file (preload hook for r0) and the external ALU
  logic [31:0] rf [32] = '{default: 32'd0};
  logic        preload_r0 = 1'b0;

  assign read_data1 = (read_reg1 == 5'd0 && preload_r0) ? 32'd5 : rf[read_reg1];
  assign read_data2 = (read_reg2 == 5'd0 && preload_r0) ? 32'd5 : rf[read_reg2];

  always @(posedge clk) if (write_enable) rf[write_reg] <= write_ctrl ? alu_out : wd;

  always_comb begin
    alu_out = 32'd0;
    case (alu_op)
      4'd0: alu_out = alu_r1 + alu_r2;
      4'd1: alu_out = alu_r1 - alu_r2;
      4'd2: alu_out = alu_r1 & alu_r2;
      4'd3: alu_out = alu_r1 | alu_r2;
      4'd4: alu_out = alu_r1 << alu_shift;
      4'd5: alu_out = alu_r1 >> alu_shift;
      4'd6: alu_out = $unsigned($signed(alu_r1) >>> alu_shift);
      4'd7: alu_out = ($signed(alu_r1) > $signed(alu_r2)) ? alu_r1 : alu_r2;
      4'd8: alu_out = ($signed(alu_r1) < $signed(alu_r2)) ? alu_r1 : alu_r2;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        err;
    logic        we;
    logic [4:0]  rd;
    logic        load;
    logic [31:0] imm;
    int          t_acc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    if (write_enable) chk("we_outside_write", {31'd0, done_valid}, 32'd1);
    if (done_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'd0, done_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_result", done_result, e.res);
        chk("done_err", {31'd0, done_err}, {31'd0, e.err});
        chk("write_enable", {31'd0, write_enable}, {31'd0, e.we});
        chk("write_reg", {27'd0, write_reg}, {27'd0, e.rd});
        chk("write_ctrl", {31'd0, write_ctrl}, {31'd0, ~e.load});
        chk("latency", cyc - e.t_acc, e.lat);
        chk("ready_in_write", {31'd0, instr_ready}, 32'd0);
        if (e.load) chk("wd", wd, e.imm);
      end
    end
  end

  int t_last = 0;
  bit last_ld = 1'b0;
  bit gap_en = 1'b0;

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [4:0] sh, input logic ld,
                       input logic [31:0] imm, input logic [31:0] eres, input logic eerr,
                       input logic ewe, input bit push);
    int n = 0;
    exp_t e;
    instr_valid = 1'b1;
    instr_op = op; instr_rs1 = rs1; instr_rs2 = rs2; instr_rd = rd;
    instr_shift = sh; instr_load = ld; instr_imm = imm;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", {31'd0, instr_ready}, 32'd1);
    end else begin
      if (gap_en) chk("accept_gap", cyc - t_last, last_ld ? 32'd3 : 32'd4);
      t_last = cyc;
      last_ld = ld;
      gap_en = 1'b1;
      e.res = eres; e.err = eerr; e.we = ewe; e.rd = rd; e.load = ld; e.imm = imm;
      e.t_acc = cyc; e.lat = ld ? 2 : 3;
      if (push) sb.push_back(e);
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_we", {31'd0, write_enable}, 32'd0);
    chk("rst_done", {31'd0, done_valid}, 32'd0);
    chk("rst_err", {31'd0, done_err}, 32'd0);
    chk("rst_wctrl", {31'd0, write_ctrl}, 32'd1);
    chk("rst_addr", {17'd0, read_reg1, read_reg2, write_reg}, 32'd0);
    chk("rst_alu", alu_r1 | alu_r2 | {23'd0, alu_shift, alu_op}, 32'd0);
    chk("rst_wd", wd, 32'd0);
    rst = 1'b0;

    //    op     rs1    rs2    rd     sh     ld    imm            result        err   we
    issue(4'd0,  5'd0,  5'd0,  5'd5,  5'd0,  1'b1, 32'd2,         32'd2,        1'b0, 1'b1, 1);
    issue(4'd0,  5'd0,  5'd0,  5'd4,  5'd0,  1'b1, 32'd1,         32'd1,        1'b0, 1'b1, 1);
    issue(4'd0,  5'd0,  5'd0,  5'd1,  5'd0,  1'b1, 32'd9,         32'd9,        1'b0, 1'b1, 1);
    issue(4'd0,  5'd0,  5'd0,  5'd2,  5'd0,  1'b1, 32'd9,         32'd9,        1'b0, 1'b1, 1);
    issue(4'd0,  5'd5,  5'd4,  5'd15, 5'd0,  1'b0, 32'd0,         32'd3,        1'b0, 1'b1, 1);
    issue(4'd0,  5'd0,  5'd0,  5'd7,  5'd0,  1'b1, 32'd30,        32'd30,       1'b0, 1'b1, 1);
    issue(4'd8,  5'd1,  5'd2,  5'd3,  5'd0,  1'b0, 32'd0,         32'd9,        1'b0, 1'b1, 1);
    issue(4'd12, 5'd5,  5'd4,  5'd6,  5'd0,  1'b0, 32'd0,         32'd0,        1'b1, 1'b0, 1);
    issue(4'd1,  5'd5,  5'd4,  5'd8,  5'd0,  1'b0, 32'd0,         32'd1,        1'b0, 1'b1, 1);
    issue(4'd4,  5'd4,  5'd0,  5'd9,  5'd3,  1'b0, 32'd0,         32'd8,        1'b0, 1'b1, 1);
    issue(4'd7,  5'd5,  5'd4,  5'd10, 5'd0,  1'b0, 32'd0,         32'd2,        1'b0, 1'b1, 1);
    issue(4'd0,  5'd10, 5'd10, 5'd12, 5'd0,  1'b0, 32'd0,         32'd4,        1'b0, 1'b1, 1);
    issue(4'd3,  5'd15, 5'd0,  5'd16, 5'd0,  1'b0, 32'd0,         32'd3,        1'b0, 1'b1, 1);
    issue(4'd5,  5'd7,  5'd0,  5'd17, 5'd2,  1'b0, 32'd0,         32'd7,        1'b0, 1'b1, 1);
    issue(4'd0,  5'd0,  5'd0,  5'd18, 5'd0,  1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1);
    issue(4'd6,  5'd18, 5'd0,  5'd19, 5'd4,  1'b0, 32'd0,         32'hF800_0000, 1'b0, 1'b1, 1);
    issue(4'd0,  5'd0,  5'd0,  5'd21, 5'd0,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
    issue(4'd0,  5'd21, 5'd4,  5'd22, 5'd0,  1'b0, 32'd0,         32'd0,        1'b0, 1'b1, 1);

    // Abandon an instruction with a reset in EXEC: no write, IDLE next cycle
    issue(4'd0,  5'd5,  5'd4,  5'd20, 5'd0,  1'b0, 32'd0,         32'd3,        1'b0, 1'b1, 0);
    @(negedge clk);
    chk("exec_alu_op", {28'd0, alu_op}, 32'd0);
    chk("exec_ready", {31'd0, instr_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("post_rst_we", {31'd0, write_enable}, 32'd0);
    @(negedge clk);
    chk("post_rst_done", {31'd0, done_valid}, 32'd0);
    gap_en = 1'b0;
    issue(4'd2,  5'd15, 5'd22, 5'd23, 5'd0,  1'b0, 32'd0,         32'd0,        1'b0, 1'b1, 1);

`ifdef ALU_SEQ_R0_ZERO_EN
    preload_r0 = 1'b1;
    issue(4'd0,  5'd5,  5'd4,  5'd0,  5'd0,  1'b0, 32'd0,         32'd3,        1'b0, 1'b0, 1);
    issue(4'd0,  5'd0,  5'd4,  5'd11, 5'd0,  1'b0, 32'd0,         32'd1,        1'b0, 1'b1, 1);
    issue(4'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 32'd5,         32'd5,        1'b0, 1'b0, 1);
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 32'd0);
    @(negedge clk);
    chk("rf_r15", rf[15], 32'd3);
    chk("rf_r7", rf[7], 32'd30);
    chk("rf_r6_illegal", rf[6], 32'd0);
    chk("rf_r20_abandoned", rf[20], 32'd0);
    chk("rf_r12", rf[12], 32'd4);
    chk("rf_r22_wrap", rf[22], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
